// File: rtl/master_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : master_port_pkg
// Brief    : Shared FSM state encoding and bus-mode constants for master_port.
// Revision : 1.0
// ============================================================================
package master_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/master_port_serial_shifter.sv
`default_nettype none
// ============================================================================
// Module   : serial_shifter
// Brief    : Parallel-load shift register (MSB out, LSB in) with bit counter.
// Revision : 1.0
// ============================================================================
module serial_shifter
  import master_port_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter int LO_WIDTH  = 8,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_data,
  input  logic                 shift,
  input  logic                 shift_in,
  input  logic                 cnt_clr,
  output logic                 msb,
  output logic [LO_WIDTH-1:0]  data_lo,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [WIDTH-1:0]     r_data;
  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= load_data;
    end else if (shift) begin
      r_data <= {r_data[WIDTH-2:0], shift_in};
    end
  end

  // Clear has priority so the last address handshake can restart the count for read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (shift) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign msb     = r_data[WIDTH-1];
  assign data_lo = r_data[LO_WIDTH-1:0];
  assign cnt     = r_cnt;

endmodule
`default_nettype wire

// File: rtl/master_port.sv
`default_nettype none
// ============================================================================
// Module   : master_port
// Brief    : Serial bus master: sends address (+ write data) MSB first, then
//            collects read data; optional handshake timeout via
//            MASTER_PORT_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module master_port
  import master_port_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mode,
  output logic                  wr_bus,
  output logic                  master_valid,
  output logic                  master_ready,
  input  logic                  rd_bus,
  input  logic                  slave_ready,
  input  logic                  slave_valid
);

  localparam int c_total = ADDR_WIDTH + DATA_WIDTH;
  localparam int c_cnt_w = $clog2(c_total + 1);
  localparam logic [c_cnt_w-1:0] c_addr_last  = c_cnt_w'(ADDR_WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_write_last = c_cnt_w'(c_total - 1);
  localparam logic [c_cnt_w-1:0] c_read_last  = c_cnt_w'(DATA_WIDTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_mode;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_accept;
  logic                  w_wr_hs;
  logic                  w_rd_hs;
  logic                  w_cnt_clr;
  logic                  w_done_nxt;
  logic                  w_timeout;
  logic                  w_msb;
  logic [DATA_WIDTH-1:0] w_load_wdata;
  logic [DATA_WIDTH-1:0] w_shift_lo;
  logic [DATA_WIDTH-1:0] w_rdata_nxt;
  logic [c_cnt_w-1:0]    w_cnt;

  assign req_ready    = (r_state == ST_IDLE);
  assign master_valid = (r_state == ST_ADDR) || (r_state == ST_WDATA);
  assign master_ready = (r_state == ST_RWAIT) || (r_state == ST_RDATA);
  assign rsp_valid    = (r_state == ST_DONE);
  assign mode         = r_mode;
  assign wr_bus       = w_msb;
  assign rsp_rdata    = r_rdata;

  assign w_accept     = req_valid && req_ready;
  assign w_wr_hs      = master_valid && slave_ready;
  assign w_rd_hs      = master_ready && slave_valid;
  assign w_load_wdata = (req_mode == MODE_READ) ? '0 : req_wdata;
  // Last read bit is still in flight on the edge into DONE, so fold it in here.
  assign w_rdata_nxt  = (w_shift_lo << 1) | DATA_WIDTH'(rd_bus);
  assign w_done_nxt   = (w_state_nxt == ST_DONE);
  assign w_cnt_clr    = w_accept || ((r_state == ST_ADDR) && (w_state_nxt == ST_RWAIT));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_ADDR;
      ST_ADDR:  if (w_wr_hs && (w_cnt == c_addr_last))
                  w_state_nxt = (r_mode == MODE_WRITE) ? ST_WDATA : ST_RWAIT;
      ST_WDATA: if (w_wr_hs && (w_cnt == c_write_last)) w_state_nxt = ST_DONE;
      ST_RWAIT: if (w_rd_hs) w_state_nxt = (w_cnt == c_read_last) ? ST_DONE : ST_RDATA;
      ST_RDATA: if (w_rd_hs && (w_cnt == c_read_last)) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_timeout) w_state_nxt = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_mode <= req_mode;
      if (w_done_nxt) r_rdata <= w_rd_hs ? w_rdata_nxt : '0;
    end
  end

  serial_shifter #(
    .WIDTH     (c_total),
    .LO_WIDTH  (DATA_WIDTH),
    .CNT_WIDTH (c_cnt_w)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (w_accept),
    .load_data ({req_addr, w_load_wdata}),
    .shift     (w_wr_hs || w_rd_hs),
    .shift_in  (rd_bus),
    .cnt_clr   (w_cnt_clr),
    .msb       (w_msb),
    .data_lo   (w_shift_lo),
    .cnt       (w_cnt)
  );

`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int c_wait_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_wait_w-1:0] r_wait;
  logic                r_err;
  logic                w_stall;

  assign w_stall   = (master_valid && !slave_ready) || (master_ready && !slave_valid);
  assign w_timeout = w_stall && (r_wait == c_wait_w'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wait <= w_stall ? r_wait + 1'b1 : '0;
      if (w_done_nxt) r_err <= w_timeout;
    end
  end
`else
  // Constant false: without the timeout option the port waits forever.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
  assign rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire
